// File: rtl/button_events.sv
// Turns debounced config/inc/dec levels into single-cycle event pulses:
// config short/long press, inc/dec step with auto-repeat, and inc+dec conflict lockout.
module button_events #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic clk_100MHz_i,
    input  logic reset_i,
    input  logic btn_config_i,
    input  logic btn_inc_i,
    input  logic btn_dec_i,
    output logic config_short_o,
    output logic config_long_o,
    output logic inc_step_o,
    output logic dec_step_o,
    output logic lock_o
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_N  = CNT_W'(REPEAT_CYCLES);

    typedef enum logic [1:0] {CFG_IDLE, CFG_PRESS, CFG_LONG} cfg_state_t;
    typedef enum logic [1:0] {STP_IDLE, STP_FIRST, STP_REPEAT, STP_LOCK} stp_state_t;

    // Hold counters stop at HOLD_CYCLES instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == HOLD_N) ? v : v + CNT_W'(1);
    endfunction

    cfg_state_t       cfg_state_q, cfg_state_d;
    logic [CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic             cfg_arm_q, cfg_arm_d;
    logic             short_q, short_d;
    logic             long_q, long_d;

    // Channel 0 is increment, channel 1 is decrement.
    stp_state_t       stp_state_q [2];
    stp_state_t       stp_state_d [2];
    logic [CNT_W-1:0] stp_cnt_q [2];
    logic [CNT_W-1:0] stp_cnt_d [2];
    logic [1:0]       stp_arm_q, stp_arm_d;
    logic [1:0]       step_q, step_d;
    logic             lock_q, lock_d;
    logic [1:0]       stp_btn;
    logic             stp_conflict;
    logic             stp_both_low;

    assign stp_btn      = {btn_dec_i, btn_inc_i};
    assign stp_conflict = btn_inc_i & btn_dec_i;
    assign stp_both_low = ~btn_inc_i & ~btn_dec_i;

    always_comb begin
        cfg_state_d = cfg_state_q;
        cfg_cnt_d   = cfg_cnt_q;
        cfg_arm_d   = cfg_arm_q | ~btn_config_i;
        short_d     = 1'b0;
        long_d      = 1'b0;
        case (cfg_state_q)
            CFG_IDLE: begin
                if (btn_config_i && cfg_arm_q) begin
                    cfg_state_d = CFG_PRESS;
                    cfg_cnt_d   = CNT_W'(1);
                end
            end
            CFG_PRESS: begin
                // Release wins over reaching the hold threshold in the same cycle.
                if (!btn_config_i) begin
                    cfg_state_d = CFG_IDLE;
                    cfg_cnt_d   = '0;
                    short_d     = 1'b1;
                end else begin
                    cfg_cnt_d = sat_inc(cfg_cnt_q);
                    if (sat_inc(cfg_cnt_q) == HOLD_N) begin
                        cfg_state_d = CFG_LONG;
                        long_d      = 1'b1;
                    end
                end
            end
            CFG_LONG: begin
                if (!btn_config_i) begin
                    cfg_state_d = CFG_IDLE;
                    cfg_cnt_d   = '0;
                end
            end
            default: begin
                cfg_state_d = CFG_IDLE;
                cfg_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            stp_state_d[ch] = stp_state_q[ch];
            stp_cnt_d[ch]   = stp_cnt_q[ch];
            stp_arm_d[ch]   = stp_arm_q[ch] | ~stp_btn[ch];
            step_d[ch]      = 1'b0;
            if (stp_conflict) begin
                stp_state_d[ch] = STP_LOCK;
                stp_cnt_d[ch]   = '0;
                stp_arm_d[ch]   = 1'b0;
            end else begin
                case (stp_state_q[ch])
                    STP_IDLE: begin
                        if (stp_btn[ch] && stp_arm_q[ch]) begin
                            stp_state_d[ch] = STP_FIRST;
                            stp_cnt_d[ch]   = '0;
                            step_d[ch]      = 1'b1;
                        end
                    end
                    STP_FIRST: begin
                        if (!stp_btn[ch]) begin
                            stp_state_d[ch] = STP_IDLE;
                            stp_cnt_d[ch]   = '0;
                        end else if (sat_inc(stp_cnt_q[ch]) == HOLD_N) begin
                            stp_state_d[ch] = STP_REPEAT;
                            stp_cnt_d[ch]   = '0;
                            step_d[ch]      = 1'b1;
                        end else begin
                            stp_cnt_d[ch] = sat_inc(stp_cnt_q[ch]);
                        end
                    end
                    STP_REPEAT: begin
                        if (!stp_btn[ch]) begin
                            stp_state_d[ch] = STP_IDLE;
                            stp_cnt_d[ch]   = '0;
                        end else if (sat_inc(stp_cnt_q[ch]) == REP_N) begin
                            stp_cnt_d[ch] = '0;
                            step_d[ch]    = 1'b1;
                        end else begin
                            stp_cnt_d[ch] = sat_inc(stp_cnt_q[ch]);
                        end
                    end
                    STP_LOCK: begin
                        if (stp_both_low) begin
                            stp_state_d[ch] = STP_IDLE;
                            stp_arm_d[ch]   = 1'b1;
                        end else begin
                            stp_arm_d[ch] = 1'b0;
                        end
                    end
                    default: begin
                        stp_state_d[ch] = STP_IDLE;
                        stp_cnt_d[ch]   = '0;
                    end
                endcase
            end
        end
        lock_d = (stp_state_d[0] == STP_LOCK);
    end

    always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
        if (reset_i) begin
            cfg_state_q <= CFG_IDLE;
            cfg_cnt_q   <= '0;
            cfg_arm_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                stp_state_q[ch] <= STP_IDLE;
                stp_cnt_q[ch]   <= '0;
            end
            stp_arm_q <= '0;
            step_q    <= '0;
            lock_q    <= 1'b0;
        end else begin
            cfg_state_q <= cfg_state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            cfg_arm_q   <= cfg_arm_d;
            short_q     <= short_d;
            long_q      <= long_d;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                stp_state_q[ch] <= stp_state_d[ch];
                stp_cnt_q[ch]   <= stp_cnt_d[ch];
            end
            stp_arm_q <= stp_arm_d;
            step_q    <= step_d;
            lock_q    <= lock_d;
        end
    end

    assign config_short_o = short_q;
    assign config_long_o  = long_q;
    assign inc_step_o     = step_q[0];
    assign dec_step_o     = step_q[1];
    assign lock_o         = lock_q;

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events: a press-duration reference model queues the
// expected output vector per clock; a monitor pops and compares it each cycle.
module tb_button_events;

    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg = 1'b0;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic short_o, long_o, inc_o, dec_o, lock_o;

    button_events #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk_100MHz_i  (clk),
        .reset_i       (rst),
        .btn_config_i  (cfg),
        .btn_inc_i     (inc),
        .btn_dec_i     (dec),
        .config_short_o(short_o),
        .config_long_o (long_o),
        .inc_step_o    (inc_o),
        .dec_step_o    (dec_o),
        .lock_o        (lock_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];
    int obs_short = 0, obs_long = 0, obs_inc = 0, obs_dec = 0, obs_lock = 0;

    // Reference model: press lengths in samples, plain arithmetic for repeat times.
    bit m_arm[3];
    int m_cfg_len;
    bit m_act[2];
    int m_k[2];
    bit m_lock;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_arm[i] = 1'b0;
        m_cfg_len = -1;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_k[i]   = 0;
        end
        m_lock = 1'b0;
    endtask

    function automatic logic [4:0] model_step(input bit c, input bit i, input bit d);
        bit sh, lg;
        bit p[2];
        bit b[2];
        sh = 0; lg = 0; p[0] = 0; p[1] = 0;
        b[0] = i; b[1] = d;
        if (m_cfg_len < 0) begin
            if (c && m_arm[0]) m_cfg_len = 1;
        end else if (!c) begin
            if (m_cfg_len < HOLD) sh = 1;
            m_cfg_len = -1;
        end else begin
            m_cfg_len++;
            if (m_cfg_len == HOLD) lg = 1;
        end
        if (!c) m_arm[0] = 1;
        if (i && d) begin
            m_lock = 1;
            m_act[0] = 0; m_act[1] = 0;
            m_arm[1] = 0; m_arm[2] = 0;
        end else if (m_lock) begin
            if (!i && !d) begin
                m_lock = 0;
                m_arm[1] = 1; m_arm[2] = 1;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!m_act[ch]) begin
                    if (b[ch] && m_arm[ch+1]) begin
                        m_act[ch] = 1;
                        m_k[ch]   = 0;
                        p[ch]     = 1;
                    end
                end else if (!b[ch]) begin
                    m_act[ch] = 0;
                end else begin
                    m_k[ch]++;
                    if (m_k[ch] == HOLD || (m_k[ch] > HOLD && (m_k[ch] - HOLD) % REP == 0))
                        p[ch] = 1;
                end
                if (!b[ch]) m_arm[ch+1] = 1;
            end
        end
        return {sh, lg, p[0], p[1], m_lock};
    endfunction

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, expv);
        end
    endtask

    // One clock: drive levels, queue the model's response for this edge.
    task automatic drive(input bit c, input bit i, input bit d);
        logic [4:0] e;
        cfg = c; inc = i; dec = d;
        e = model_step(c, i, d);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic apply_reset(input bit c, input bit i, input bit d);
        @(negedge clk);
        #1;
        rst = 1'b1;
        cfg = c; inc = i; dec = d;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({short_o, long_o, inc_o, dec_o, lock_o}), 0);
        rst = 1'b0;
    endtask

    task automatic hold(input int n, input bit c, input bit i, input bit d);
        for (int k = 0; k < n; k++) drive(c, i, d);
    endtask

    initial begin : monitor
        logic [4:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {short_o, long_o, inc_o, dec_o, lock_o};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got=%b expected=%b (short,long,inc,dec,lock)",
                             $time, a, e);
                end
                obs_short += int'(a[4]);
                obs_long  += int'(a[3]);
                obs_inc   += int'(a[2]);
                obs_dec   += int'(a[1]);
                obs_lock  += int'(a[0]);
            end
        end
    end

    initial begin : stim
        int s0, l0, i0, d0, k0;
        int dur[3];
        bit lvl[3];
        int waited;

        model_reset();
        apply_reset(0, 0, 0);
        hold(2, 0, 0, 0);

        // Short config press
        s0 = obs_short; l0 = obs_long;
        hold(4, 1, 0, 0);
        hold(4, 0, 0, 0);
        check("short_count", obs_short - s0, 1);
        check("short_no_long", obs_long - l0, 0);

        // Long config press
        s0 = obs_short; l0 = obs_long;
        hold(20, 1, 0, 0);
        hold(4, 0, 0, 0);
        check("long_count", obs_long - l0, 1);
        check("long_no_short", obs_short - s0, 0);

        // Boundary: release exactly when the counter would hit HOLD
        s0 = obs_short; l0 = obs_long;
        hold(HOLD - 1, 1, 0, 0);
        hold(4, 0, 0, 0);
        check("edge_short", obs_short - s0, 1);
        check("edge_no_long", obs_long - l0, 0);

        // Inc auto-repeat
        i0 = obs_inc; d0 = obs_dec;
        hold(20, 0, 1, 0);
        hold(4, 0, 0, 0);
        check("inc_repeat_count", obs_inc - i0, 5);
        check("inc_repeat_no_dec", obs_dec - d0, 0);

        // Conflict during inc hold, then fresh dec press
        i0 = obs_inc; d0 = obs_dec; k0 = obs_lock;
        hold(5, 0, 1, 0);
        hold(10, 0, 1, 1);
        hold(4, 0, 0, 0);
        check("conflict_inc_count", obs_inc - i0, 1);
        check("conflict_lock_cycles", obs_lock - k0, 10);
        hold(2, 0, 0, 1);
        hold(4, 0, 0, 0);
        check("post_lock_dec", obs_dec - d0, 1);

        // Dec held across reset release
        apply_reset(0, 0, 1);
        d0 = obs_dec;
        hold(12, 0, 0, 1);
        check("held_through_reset", obs_dec - d0, 0);
        hold(2, 0, 0, 0);
        hold(1, 0, 0, 1);
        hold(4, 0, 0, 0);
        check("repress_after_reset", obs_dec - d0, 1);

        // Simultaneous rising edges
        i0 = obs_inc; d0 = obs_dec; k0 = obs_lock;
        hold(6, 0, 1, 1);
        hold(4, 0, 0, 0);
        check("simul_steps", (obs_inc - i0) + (obs_dec - d0), 0);
        check("simul_lock_cycles", obs_lock - k0, 6);

        // Randomized levels with occasional reset
        for (int b = 0; b < 3; b++) begin
            dur[b] = 0;
            lvl[b] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    dur[b] = int'($urandom_range(1, 25));
                end
                dur[b]--;
            end
            if ($urandom_range(0, 399) == 0) apply_reset(lvl[0], lvl[1], lvl[2]);
            else drive(lvl[0], lvl[1], lvl[2]);
        end
        hold(3, 0, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Converts the three debounced button levels into single-cycle event pulses for the watch control logic.
- Sits between the debounce instances and the watch module.
- Config button: short press or long press.
- Increment and decrement buttons: one step on press, then auto-repeat while held.
- Inc+dec held together is treated as invalid and produces no steps.

Parameters:
- HOLD_CYCLES, 50_000_000, cycles a button must stay held before long-press or auto-repeat starts (500 ms at 100 MHz); must be >= 2.
- REPEAT_CYCLES, 10_000_000, cycles between auto-repeat pulses (100 ms at 100 MHz); must be >= 1 and <= HOLD_CYCLES.

Ports:
- clk_100MHz_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- btn_config_i  in  1  debounced config level, 1 = pressed
- btn_inc_i  in  1  debounced increment level
- btn_dec_i  in  1  debounced decrement level
- config_short_o  out  1  one-cycle pulse: config released before HOLD_CYCLES
- config_long_o  out  1  one-cycle pulse: config held for HOLD_CYCLES
- inc_step_o  out  1  one-cycle increment step pulse
- dec_step_o  out  1  one-cycle decrement step pulse
- lock_o  out  1  level, 1 while inc/dec are in conflict lockout

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While reset_i = 1, all outputs are 0, all FSMs are in IDLE and all counters are 0.
- All outputs are registered. Inputs are used directly; they are already synchronous.
- Arming:
  - After reset, or after a lockout, a button that is already high is ignored until it is sampled low once.
  - Each button has its own arm flag, cleared by reset and set on the first low sample.
- Timer: each FSM has its own hold counter, width $clog2(HOLD_CYCLES+1). It saturates and never wraps.
- Config FSM:
  - IDLE -> PRESS when the input is sampled high and armed. The counter starts at 1.
  - PRESS, input low -> IDLE and config_short_o = 1 on the next cycle. This is 1-cycle latency from the first low sample.
  - PRESS, counter reaches HOLD_CYCLES while input high -> LONG and config_long_o = 1 for exactly one cycle.
  - LONG -> IDLE on release, with no pulse.
  - A release in the same cycle the counter would reach HOLD_CYCLES counts as short.
- Inc/dec FSM (one instance per button): IDLE, FIRST, REPEAT.
  - IDLE -> FIRST on an armed high sample. The step output pulses on the next cycle (latency 1) and the counter clears.
  - FIRST: after HOLD_CYCLES cycles following the first pulse, with the input still high, emit a step pulse -> REPEAT and clear the counter.
  - REPEAT: emit a step pulse every REPEAT_CYCLES cycles while the input is high.
  - Release in any state -> IDLE immediately. No pulse is emitted in the cycle of the release sample.
- Conflict:
  - If btn_inc_i and btn_dec_i are both high in any sample, both inc/dec FSMs go to LOCK and lock_o = 1 from the next cycle.
  - No steps are produced in the conflict cycle or afterwards, including a step that would otherwise have been scheduled that cycle.
  - LOCK exits to IDLE only when both inputs are sampled low in the same cycle. Both arm flags are then set.
  - Rising edges of inc and dec in the same cycle -> straight to LOCK, no pulses.
- The config FSM is fully independent of inc/dec; config pulses may coincide with step pulses.
- inc_step_o and dec_step_o are never 1 in the same cycle.
- Reset mid-hold: all pulses stop immediately. After reset, a still-held button produces nothing until it is released and pressed again.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=3):
1. Reset, then press config for 4 cycles and release -> config_short_o pulses once, 1 cycle after the first low sample; config_long_o stays 0.
2. Hold config for 20 cycles -> config_long_o pulses once, at the cycle after the 8th high sample; no config_short_o on release.
3. Hold inc for 20 cycles -> inc_step_o pulses at offsets 1, 9, 12, 15, 18 from the first high sample (5 pulses); dec_step_o stays 0.
4. Hold inc, assert dec at offset 5, release both at offset 15 -> one inc pulse only; lock_o high from offset 6 until the cycle after both are low; a fresh dec press then gives one dec pulse.
5. Hold dec across deassertion of reset_i -> no pulses while held; after release and re-press, dec_step_o pulses with 1-cycle latency.
6. Raise inc and dec in the same cycle, then drop them together -> no step pulses; lock_o high for the duration.
